// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash DMA write-back engine: state encoding,
// address step and byte-to-word conversion.
package spi_flash_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t FETCH = 2'd1;
  localparam state_t WRITE = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam int unsigned ADDR_INC = 4;

  // Round a byte count up to whole 32-bit words; the sum is kept wide so +3 cannot overflow.
  function automatic logic [31:0] bytes_to_words(input logic [31:0] bytes);
    return 32'((34'(bytes) + 34'd3) >> 2);
  endfunction

endpackage

// File: rtl/spi_flash_dma_wr_if.sv
// AHB master write-request channel driven by the DMA write-back engine.
interface spi_flash_dma_wr_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_rd0_wr1;
  logic              o_valid;
  logic              i_ready;

  modport master (
    output o_addr,
    output o_wr_data,
    output o_rd0_wr1,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_addr,
    input  o_wr_data,
    input  o_rd0_wr1,
    input  o_valid,
    output i_ready
  );

endinterface

// File: rtl/spi_flash_dma_wr.sv
// DMA write-back engine: pops flash words from a FWFT FIFO and writes them to
// consecutive memory addresses over the AHB master request channel.
module spi_flash_dma_wr #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned ADDR_INC = spi_flash_pkg::ADDR_INC
) (
  input  logic              ahbclk,
  input  logic              ahbrst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_byte_cnt,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_rdata,
  output logic              o_fifo_rd_en,
  spi_flash_dma_wr_if.master bus,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-3:0]  o_words_done
);

  import spi_flash_pkg::*;

  localparam int unsigned WL_W = CNT_W - 1;
  localparam int unsigned WD_W = CNT_W - 2;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [WL_W-1:0]   words_left_q;
  logic [WD_W-1:0]   words_done_q;
  logic              abort_pend_q;
  logic [WL_W-1:0]   start_words;
  logic              accept;
  logic              pop;
  logic              valid;

  assign start_words = WL_W'(bytes_to_words(32'(i_byte_cnt)));
  assign accept      = (state_q == WRITE) && bus.i_ready;

  // State register
  always_ff @(posedge ahbclk) begin
    if (ahbrst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an abort seen in WRITE only takes effect once the request is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = (start_words == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (i_abort)            state_d = IDLE;
        else if (!i_fifo_empty) state_d = WRITE;
      end
      WRITE: begin
        if (accept) begin
          if (abort_pend_q || i_abort)       state_d = IDLE;
          else if (words_left_q == WL_W'(1)) state_d = DONE;
          else                               state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; the pop is suppressed on a reset or abort cycle
  always_comb begin
    pop    = 1'b0;
    valid  = 1'b0;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (state_q)
      FETCH: begin
        pop    = !i_fifo_empty && !i_abort && !ahbrst;
        o_busy = 1'b1;
      end
      WRITE: begin
        valid  = 1'b1;
        o_busy = 1'b1;
      end
      DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_fifo_rd_en  = pop;
  assign bus.o_valid   = valid;
  assign bus.o_rd0_wr1 = valid;
  assign bus.o_addr    = addr_q;
  assign bus.o_wr_data = data_q;
  assign o_words_done  = words_done_q;

  // Address, data and word counters
  always_ff @(posedge ahbclk) begin
    if (ahbrst) begin
      addr_q       <= '0;
      data_q       <= '0;
      words_left_q <= '0;
      words_done_q <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            addr_q       <= i_base_addr;
            words_left_q <= start_words;
            words_done_q <= '0;
            abort_pend_q <= 1'b0;
          end
        end
        FETCH: begin
          if (pop) data_q <= i_fifo_rdata;
        end
        WRITE: begin
          if (accept) begin
            addr_q       <= addr_q + ADDR_W'(ADDR_INC);
            words_left_q <= words_left_q - WL_W'(1);
            words_done_q <= words_done_q + WD_W'(1);
            abort_pend_q <= 1'b0;
          end else if (i_abort) begin
            abort_pend_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_dma_wr.sv
// Self-checking bench for spi_flash_dma_wr: table-driven transfers scored
// against a write queue, plus hand sequences for abort, reset and starvation.
module tb_spi_flash_dma_wr;

  logic        ahbclk = 1'b0;
  logic        ahbrst;
  logic        i_start;
  logic        i_abort;
  logic [31:0] i_base_addr;
  logic [23:0] i_byte_cnt;
  logic        i_fifo_empty;
  logic [31:0] i_fifo_rdata;
  logic        o_fifo_rd_en;
  logic        o_busy;
  logic        o_done;
  logic [21:0] o_words_done;

  spi_flash_dma_wr_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  spi_flash_dma_wr #(.ADDR_W(32), .DATA_W(32), .CNT_W(24), .ADDR_INC(4)) dut (
    .ahbclk       (ahbclk),
    .ahbrst       (ahbrst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_base_addr  (i_base_addr),
    .i_byte_cnt   (i_byte_cnt),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_rdata (i_fifo_rdata),
    .o_fifo_rd_en (o_fifo_rd_en),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_words_done (o_words_done)
  );

  always #5 ahbclk = ~ahbclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] base;
    logic [23:0] cnt;
    int          stall;
    int          restart_at;
    logic [31:0] d0;
    int          exp_words;
  } row_t;

  logic [31:0] fifo_q[$];
  exp_t        sb[$];
  int n_chk = 0, n_pass = 0;
  int n_pops, n_writes, n_done, cyc_cnt, first_valid, done_cyc;
  int stall = 0, wait_cnt = 0;
  logic hold = 1'b0, last_rd_en = 1'b0;
  logic [31:0] hold_addr, hold_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic fifo_refresh();
    i_fifo_empty = (fifo_q.size() == 0);
    i_fifo_rdata = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
  endtask

  task automatic fifo_push(input logic [31:0] d);
    fifo_q.push_back(d);
    fifo_refresh();
  endtask

  task automatic flush();
    fifo_q.delete();
    sb.delete();
    fifo_refresh();
    hold = 1'b0;
    wait_cnt = 0;
    stall = 0;
    bus.i_ready = 1'b1;
  endtask

  task automatic clr();
    n_pops = 0; n_writes = 0; n_done = 0; cyc_cnt = 0;
    first_valid = -1; done_cyc = -1;
  endtask

  // One clock: monitor at the falling edge, then update FIFO model and ready after the rising edge
  task automatic step();
    logic do_pop;
    exp_t e;
    cyc_cnt++;
    @(negedge ahbclk);
    last_rd_en = o_fifo_rd_en;
    do_pop = o_fifo_rd_en;
    if (o_fifo_rd_en) begin
      n_pops++;
      chk("pop_while_valid", 64'(bus.o_valid), 64'd0);
      chk("pop_from_empty", 64'(i_fifo_empty), 64'd0);
    end
    if (bus.o_valid && first_valid < 0) first_valid = cyc_cnt;
    if (bus.o_valid && hold) begin
      chk("hold_addr", 64'(bus.o_addr), 64'(hold_addr));
      chk("hold_data", 64'(bus.o_wr_data), 64'(hold_data));
    end
    if (bus.o_valid && bus.i_ready) begin
      n_writes++;
      chk("wr_dir", 64'(bus.o_rd0_wr1), 64'd1);
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", bus.o_addr, bus.o_wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 64'(bus.o_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.o_wr_data), 64'(e.data));
      end
      hold = 1'b0;
      wait_cnt = 0;
    end else if (bus.o_valid) begin
      hold = 1'b1;
      hold_addr = bus.o_addr;
      hold_data = bus.o_wr_data;
      wait_cnt++;
    end else begin
      hold = 1'b0;
    end
    if (o_done) begin
      n_done++;
      if (done_cyc < 0) done_cyc = cyc_cnt;
    end
    @(posedge ahbclk);
    #1;
    if (do_pop && fifo_q.size() > 0) fifo_q.delete(0);
    fifo_refresh();
    bus.i_ready = (wait_cnt >= stall);
  endtask

  task automatic run_to_done(input int bound);
    for (int c = 0; c < bound && n_done == 0; c++) step();
    if (n_done == 0) begin
      n_chk++;
      $display("FAIL done_timeout: got no o_done within %0d cycles expected one", bound);
    end
  endtask

  task automatic run_row(input int idx, input row_t r);
    clr();
    flush();
    stall = r.stall;
    bus.i_ready = (stall == 0);
    for (int i = 0; i < r.exp_words; i++) begin
      fifo_push(r.d0 + 32'(i));
      sb.push_back('{addr: r.base + 32'(4 * i), data: r.d0 + 32'(i)});
    end
    i_base_addr = r.base;
    i_byte_cnt  = r.cnt;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    i_base_addr = 32'hDEAD_0000;
    i_byte_cnt  = 24'd100;
    for (int c = 0; c < 400 && n_done == 0; c++) begin
      i_start = (cyc_cnt + 1 == r.restart_at);
      step();
    end
    i_start = 1'b0;
    if (n_done == 0) begin
      n_chk++;
      $display("FAIL row%0d_timeout: got no o_done expected one", idx);
    end
    repeat (3) step();
    chk($sformatf("row%0d_writes", idx), 64'(n_writes), 64'(r.exp_words));
    chk($sformatf("row%0d_pops", idx), 64'(n_pops), 64'(r.exp_words));
    chk($sformatf("row%0d_done_pulses", idx), 64'(n_done), 64'd1);
    chk($sformatf("row%0d_words_done", idx), 64'(o_words_done), 64'(r.exp_words));
    chk($sformatf("row%0d_sb_left", idx), 64'(sb.size()), 64'd0);
    chk($sformatf("row%0d_busy_end", idx), 64'(o_busy), 64'd0);
    if (r.exp_words > 0) chk($sformatf("row%0d_first_valid_cyc", idx), 64'(first_valid), 64'd3);
    else                 chk($sformatf("row%0d_done_cyc", idx), 64'(done_cyc), 64'd2);
  endtask

  row_t rows[7];

  initial begin
    rows[0] = '{base: 32'h2000_0000, cnt: 24'd16, stall: 0, restart_at: 0, d0: 32'h0000_00A0, exp_words: 4};
    rows[1] = '{base: 32'h1000_0100, cnt: 24'd5,  stall: 3, restart_at: 0, d0: 32'h55AA_0000, exp_words: 2};
    rows[2] = '{base: 32'h3000_0000, cnt: 24'd0,  stall: 0, restart_at: 0, d0: 32'h0,         exp_words: 0};
    rows[3] = '{base: 32'hFFFF_FFFC, cnt: 24'd8,  stall: 0, restart_at: 0, d0: 32'hC0DE_0000, exp_words: 2};
    rows[4] = '{base: 32'h4000_0000, cnt: 24'd16, stall: 0, restart_at: 5, d0: 32'h1234_0000, exp_words: 4};
    rows[5] = '{base: 32'h5000_0010, cnt: 24'd1,  stall: 1, restart_at: 0, d0: 32'h9876_5430, exp_words: 1};
    rows[6] = '{base: 32'h6000_0000, cnt: 24'd7,  stall: 2, restart_at: 0, d0: 32'h0BAD_F000, exp_words: 2};

    ahbrst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_base_addr = '0; i_byte_cnt = '0;
    flush();
    clr();
    repeat (2) step();
    ahbrst = 1'b0;
    chk("rst_addr", 64'(bus.o_addr), 64'd0);
    chk("rst_data", 64'(bus.o_wr_data), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_dir", 64'(bus.o_rd0_wr1), 64'd0);
    chk("rst_rd_en", 64'(o_fifo_rd_en), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_words_done", 64'(o_words_done), 64'd0);

    foreach (rows[i]) run_row(i, rows[i]);

    // FIFO starvation: engine waits in FETCH without popping or requesting
    clr(); flush();
    i_base_addr = 32'h7000_0000; i_byte_cnt = 24'd8; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (10) step();
    chk("starve_pops", 64'(n_pops), 64'd0);
    chk("starve_writes", 64'(n_writes), 64'd0);
    chk("starve_busy", 64'(o_busy), 64'd1);
    for (int i = 0; i < 2; i++) begin
      fifo_push(32'hFEED_0000 + 32'(i));
      sb.push_back('{addr: 32'h7000_0000 + 32'(4 * i), data: 32'hFEED_0000 + 32'(i)});
    end
    run_to_done(40);
    step();
    chk("starve_writes_end", 64'(n_writes), 64'd2);
    chk("starve_sb_left", 64'(sb.size()), 64'd0);

    // Start and abort together in IDLE: start wins
    clr(); flush();
    fifo_push(32'h1111_2222);
    sb.push_back('{addr: 32'h0800_0000, data: 32'h1111_2222});
    i_base_addr = 32'h0800_0000; i_byte_cnt = 24'd4;
    i_start = 1'b1; i_abort = 1'b1;
    step();
    i_start = 1'b0; i_abort = 1'b0;
    chk("start_abort_busy", 64'(o_busy), 64'd1);
    run_to_done(20);
    chk("start_abort_writes", 64'(n_writes), 64'd1);

    // Abort in FETCH: back to IDLE, no pop, no completion
    clr(); flush();
    i_base_addr = 32'h0900_0000; i_byte_cnt = 24'd8; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    i_abort = 1'b1;
    fifo_push(32'h3333_4444);
    step();
    i_abort = 1'b0;
    chk("abort_fetch_rd_en", 64'(last_rd_en), 64'd0);
    chk("abort_fetch_busy", 64'(o_busy), 64'd0);
    repeat (3) step();
    chk("abort_fetch_done", 64'(n_done), 64'd0);
    chk("abort_fetch_pops", 64'(n_pops), 64'd0);

    // Abort in WRITE while stalled: request held until accepted, then IDLE without done
    clr(); flush();
    stall = 1000; bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_push(32'h5000_0000 + 32'(i));
    sb.push_back('{addr: 32'h0A00_0000, data: 32'h5000_0000});
    i_base_addr = 32'h0A00_0000; i_byte_cnt = 24'd12; i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (2) step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    repeat (3) step();
    chk("abort_wr_valid_held", 64'(bus.o_valid), 64'd1);
    chk("abort_wr_addr_held", 64'(bus.o_addr), 64'h0A00_0000);
    chk("abort_wr_no_write_yet", 64'(n_writes), 64'd0);
    stall = 0; bus.i_ready = 1'b1;
    step();
    chk("abort_wr_valid_drop", 64'(bus.o_valid), 64'd0);
    chk("abort_wr_busy", 64'(o_busy), 64'd0);
    repeat (3) step();
    chk("abort_wr_done", 64'(n_done), 64'd0);
    chk("abort_wr_writes", 64'(n_writes), 64'd1);
    chk("abort_wr_pops", 64'(n_pops), 64'd1);
    chk("abort_wr_words_done", 64'(o_words_done), 64'd1);
    chk("abort_wr_sb_left", 64'(sb.size()), 64'd0);

    // Reset during FETCH with data arriving: no pop on the reset cycle
    clr(); flush();
    i_base_addr = 32'h0B00_0000; i_byte_cnt = 24'd4; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    fifo_push(32'h7777_8888);
    ahbrst = 1'b1;
    step();
    ahbrst = 1'b0;
    chk("rst_fetch_rd_en", 64'(last_rd_en), 64'd0);
    chk("rst_fetch_busy", 64'(o_busy), 64'd0);

    // Reset mid-WRITE after one completed word: all outputs clear on the next edge
    clr(); flush();
    fifo_push(32'hAAAA_0001);
    fifo_push(32'hAAAA_0002);
    sb.push_back('{addr: 32'h0C00_0010, data: 32'hAAAA_0001});
    i_base_addr = 32'h0C00_0010; i_byte_cnt = 24'd8; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 20 && n_writes == 0; c++) step();
    stall = 1000; bus.i_ready = 1'b0;
    for (int c = 0; c < 10 && !bus.o_valid; c++) step();
    chk("rst_wr_pre_valid", 64'(bus.o_valid), 64'd1);
    chk("rst_wr_pre_words", 64'(o_words_done), 64'd1);
    ahbrst = 1'b1;
    step();
    ahbrst = 1'b0;
    chk("rst_wr_addr", 64'(bus.o_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.o_wr_data), 64'd0);
    chk("rst_wr_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_wr_dir", 64'(bus.o_rd0_wr1), 64'd0);
    chk("rst_wr_rd_en", 64'(o_fifo_rd_en), 64'd0);
    chk("rst_wr_busy", 64'(o_busy), 64'd0);
    chk("rst_wr_done", 64'(o_done), 64'd0);
    chk("rst_wr_words_done", 64'(o_words_done), 64'd0);
    repeat (3) step();
    chk("rst_wr_writes", 64'(n_writes), 64'd1);
    flush();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
